logic_alu_pipe: RTL and testbench
=================================

// Module: logic_alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the 32-bit combinational add/sub/logic unit.
//  Takes one operand pair plus an opcode per AXI-Stream-style beat and returns one selected result with status flags.
//  Latency is 2 cycles, with full backpressure support.
//  Sits between stream FIFOs in the datapath: consumes from one FIFO's read side, feeds the next FIFO's write side.
// PARAMETERS
//  DATA_W     32  operand/result width in bits (>=2)
//  USER_W     4   sideband tag carried alongside each beat, unmodified
// PORTS
//  aclk           in   1         single clock, all logic rising-edge
//  aresetn        in   1         synchronous, active-low reset
//  s_valid        in   1         input beat valid
//  s_ready        out  1         input beat accepted when s_valid&&s_ready
//  s_a            in   DATA_W    operand A
//  s_b            in   DATA_W    operand B
//  s_op           in   3         opcode (see BEHAVIOUR)
//  s_user         in   USER_W    sideband tag
//  m_valid        out  1         result beat valid
//  m_ready        in   1         downstream accepts when m_valid&&m_ready
//  m_result       out  DATA_W    selected result
//  m_user         out  USER_W    tag of the originating input beat
//  m_flags        out  5         {err, neg, zero, ovf, carry}
// BEHAVIOUR
//  - Reset (aresetn=0 at a clock edge): both stage valids, m_valid, m_result, m_user and m_flags are 0.
//    s_ready is 0 while aresetn=0 and 1 on the first cycle after release.
//  - Two register stages:
//    - S1 registers a, b, op, user.
//    - S2 computes the result/flags from S1 and registers them onto the m_* outputs.
//    - Accepted beat appears on m_* exactly 2 cycles after acceptance when m_ready is held 1.
//  - Stage advance: stage k loads when (!valid_k || advance_k+1); S2 advances on m_ready.
//    - s_ready = !valid1 || !valid2 || m_ready.
//    - Full throughput (1 beat/cycle) when m_ready=1.
//  - While m_valid=1 && m_ready=0, m_result/m_user/m_flags are held stable; no beat is dropped or duplicated.
//  - Beats leave in acceptance order. Simultaneous accept-in and drain-out in one cycle is legal.
//  - Opcodes:
//    - 0 ADD: a+b mod 2^DATA_W
//    - 1 SUB: a-b mod 2^DATA_W
//    - 2 AND
//    - 3 OR
//    - 4 XOR
//    - 5 XNOR
//    - 6-7 illegal: result 0, err=1
//  - Flags:
//    - carry: ADD carry-out of bit DATA_W-1; SUB borrow (1 iff a<b unsigned); 0 for logic ops.
//    - ovf: signed overflow for ADD/SUB; 0 otherwise.
//    - zero: result==0, including illegal ops.
//    - neg: result[DATA_W-1].
//    - err: illegal opcode only.
//  - Reset mid-operation: all in-flight beats are discarded, none emitted after release.
// STRUCTURE
//  - Shared package logic_alu_pkg: opcode localparams (OP_ADD..OP_XNOR), flag bit indices, FLAG_W=5.
//  - Sub-module logic_alu_core: purely combinational (a,b,op)->(result,flags), parametrised by DATA_W.
//  - Top holds the two handshake pipeline stages only.
// TESTING
//  1 Reset: hold aresetn=0 for 3 cycles with s_valid=1 -> s_ready=0, m_valid=0, m_result=0.
//    After release: s_ready=1, m_valid stays 0.
//  2 ADD: DATA_W=32, a=0xFFFFFFFF, b=1, op=0, m_ready=1 -> after 2 cycles result=0, flags carry=1, zero=1, ovf=0.
//    SUB: a=0x80000000, b=1 -> result 0x7FFFFFFF, ovf=1, carry=0.
//  3 Logic/illegal: a=0xF0F0F0F0, b=0xFF00FF00, ops 2..5 -> 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0xF00FF00F.
//    op=7 -> result 0, err=1, zero=1.
//  4 Backpressure: stream 8 beats (user=0..7), m_ready pattern 1,0,0,1,... -> all 8 out in order, no gaps.
//    Data stable while stalled; s_ready=0 only when both stages full and m_ready=0.
//  5 Reset mid-flight: 2 beats in pipe, pulse aresetn=0 one cycle -> m_valid=0 next cycle, neither beat emitted.
//  6 Width sweep: DATA_W=8, a=0x7F, b=0x01, ADD -> 0x80, ovf=1, neg=1, carry=0.

Source files
------------

// File: rtl/logic_alu_pkg.sv
// Shared definitions for the pipelined logic/arithmetic unit: opcode encodings
// and the bit positions of the status flags.
package logic_alu_pkg;

    localparam int OP_W   = 3;
    localparam int FLAG_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

    // m_flags packs {err, neg, zero, ovf, carry}
    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ERR   = 4;

endpackage

// File: rtl/logic_alu_core.sv
// Combinational datapath: one operand pair and opcode in, selected result
// and status flags out.
module logic_alu_core
    import logic_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            carry;
    logic            ovf;
    logic            err;

    // Extra top bit captures the ADD carry-out and the SUB borrow (a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Opcode decode and arithmetic flag generation.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
                ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            default: err = 1'b1;
        endcase
    end

    // Flag vector assembly; zero and neg follow whatever result was selected.
    always_comb begin
        flags             = '0;
        flags[FLAG_CARRY] = carry;
        flags[FLAG_OVF]   = ovf;
        flags[FLAG_ZERO]  = (result == '0);
        flags[FLAG_NEG]   = result[DATA_W-1];
        flags[FLAG_ERR]   = err;
    end

endmodule

// File: rtl/logic_alu_pipe.sv
// Two-stage valid/ready pipeline around logic_alu_core: stage 1 registers the
// operands, stage 2 registers the computed result onto the m_* outputs.
module logic_alu_pipe
    import logic_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int USER_W = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    input  logic [OP_W-1:0]   s_op,
    input  logic [USER_W-1:0] s_user,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_result,
    output logic [USER_W-1:0] m_user,
    output logic [FLAG_W-1:0] m_flags
);

    logic              valid1;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic [OP_W-1:0]   op1;
    logic [USER_W-1:0] user1;

    logic              load1;
    logic              load2;
    logic [DATA_W-1:0] core_result;
    logic [FLAG_W-1:0] core_flags;

    // A stage may take new data when it is empty or its content moves on this cycle.
    assign load2   = !m_valid || m_ready;
    assign load1   = !valid1 || load2;
    assign s_ready = aresetn && load1;

    logic_alu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .a      (a1),
        .b      (b1),
        .op     (op1),
        .result (core_result),
        .flags  (core_flags)
    );

    // Stage 1: operand capture.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            valid1 <= 1'b0;
            a1     <= '0;
            b1     <= '0;
            op1    <= '0;
            user1  <= '0;
        end else if (load1) begin
            valid1 <= s_valid;
            a1     <= s_a;
            b1     <= s_b;
            op1    <= s_op;
            user1  <= s_user;
        end
    end

    // Stage 2: result registers; payload only changes when a new beat lands, so it holds under stall.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_valid  <= 1'b0;
            m_result <= '0;
            m_user   <= '0;
            m_flags  <= '0;
        end else if (load2) begin
            m_valid <= valid1;
            if (valid1) begin
                m_result <= core_result;
                m_user   <= user1;
                m_flags  <= core_flags;
            end
        end
    end

endmodule

// File: tb/tb_logic_alu_pipe.sv
// Self-checking bench: directed steps plus randomized traffic checked against
// an arithmetic reference model and an in-order expectation queue.
module tb_logic_alu_pipe;

    logic        aclk;
    logic        aresetn;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic [2:0]  s_op;
    logic [3:0]  s_user;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_result;
    logic [3:0]  m_user;
    logic [4:0]  m_flags;

    logic        s_valid8;
    logic        s_ready8;
    logic [7:0]  s_a8;
    logic [7:0]  s_b8;
    logic [2:0]  s_op8;
    logic [3:0]  s_user8;
    logic        m_valid8;
    logic        m_ready8;
    logic [7:0]  m_result8;
    logic [3:0]  m_user8;
    logic [4:0]  m_flags8;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  fl;
        logic [3:0]  user;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          popped   = 0;
    int          rst_cycles = 0;
    logic        last_acc;
    logic        hold_v = 1'b0;
    logic [31:0] hold_res;
    logic [3:0]  hold_user;
    logic [4:0]  hold_fl;

    logic_alu_pipe #(.DATA_W(32), .USER_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_op(s_op), .s_user(s_user),
        .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_user(m_user), .m_flags(m_flags)
    );

    logic_alu_pipe #(.DATA_W(8), .USER_W(4)) dut8 (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid8), .s_ready(s_ready8), .s_a(s_a8), .s_b(s_b8), .s_op(s_op8), .s_user(s_user8),
        .m_valid(m_valid8), .m_ready(m_ready8), .m_result(m_result8), .m_user(m_user8), .m_flags(m_flags8)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: w-bit unsigned/signed arithmetic on plain integers.
    function automatic void model_alu(input int w, input longint unsigned a, input longint unsigned b,
                                      input int op, output longint unsigned res, output logic [4:0] fl);
        longint unsigned mask, ua, ub, full;
        longint          sa, sb, sres, half;
        logic            c, v, e, n;
        mask = (64'd1 << w) - 64'd1;
        ua   = a & mask;
        ub   = b & mask;
        half = longint'(64'd1 << (w - 1));
        sa   = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
        sb   = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
        c = 1'b0; v = 1'b0; e = 1'b0; res = 64'd0;
        case (op)
            0: begin
                full = ua + ub;
                res  = full & mask;
                c    = (full > mask);
                sres = sa + sb;
                v    = (sres >= half) || (sres < -half);
            end
            1: begin
                res  = (ua - ub) & mask;
                c    = (ua < ub);
                sres = sa - sb;
                v    = (sres >= half) || (sres < -half);
            end
            2: res = ua & ub;
            3: res = ua | ub;
            4: res = ua ^ ub;
            5: res = ~(ua ^ ub) & mask;
            default: e = 1'b1;
        endcase
        n  = ((res >> (w - 1)) & 64'd1) != 64'd0;
        fl = {e, n, (res == 64'd0), v, c};
    endfunction

    // One clock: observe handshakes at the falling edge, then move to just after the rising edge.
    task automatic cyc();
        longint unsigned r;
        logic [4:0]      f;
        exp_t            e;
        @(negedge aclk);
        last_acc = 1'b0;
        if (!aresetn) begin
            rst_cycles++;
            chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
            if (rst_cycles > 1) begin
                chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
                chk("rst_m_result", {32'd0, m_result}, 64'd0);
                chk("rst_m_flags", {59'd0, m_flags}, 64'd0);
            end
            q.delete();
            hold_v = 1'b0;
        end else begin
            rst_cycles = 0;
            chk("s_ready", {63'd0, s_ready}, {63'd0, (q.size() < 2) || m_ready});
            if (hold_v) begin
                chk("stall_valid", {63'd0, m_valid}, 64'd1);
                chk("stall_result", {32'd0, m_result}, {32'd0, hold_res});
                chk("stall_user", {60'd0, m_user}, {60'd0, hold_user});
                chk("stall_flags", {59'd0, m_flags}, {59'd0, hold_fl});
            end
            hold_v    = m_valid && !m_ready;
            hold_res  = m_result;
            hold_user = m_user;
            hold_fl   = m_flags;
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_beat", {63'd0, m_valid}, 64'd0);
                end else begin
                    e = q.pop_front();
                    popped++;
                    chk("sb_result", {32'd0, m_result}, {32'd0, e.res});
                    chk("sb_flags", {59'd0, m_flags}, {59'd0, e.fl});
                    chk("sb_user", {60'd0, m_user}, {60'd0, e.user});
                end
            end
            if (s_valid && s_ready) begin
                model_alu(32, {32'd0, s_a}, {32'd0, s_b}, int'(s_op), r, f);
                e.res  = r[31:0];
                e.fl   = f;
                e.user = s_user;
                q.push_back(e);
                last_acc = 1'b1;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [31:0] er, input logic [4:0] ef);
        s_a = a; s_b = b; s_op = op; s_user = 4'($urandom_range(0, 15));
        s_valid = 1'b1; m_ready = 1'b1;
        cyc();
        s_valid = 1'b0;
        cyc();
        chk({tag, "_valid"}, {63'd0, m_valid}, 64'd1);
        chk({tag, "_result"}, {32'd0, m_result}, {32'd0, er});
        chk({tag, "_flags"}, {59'd0, m_flags}, {59'd0, ef});
        cyc();
    endtask

    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic [2:0]  top [8];

    initial begin
        longint unsigned r8;
        logic [4:0]      f8;
        int              sent;
        int              base;

        aresetn = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        s_a = 32'd5; s_b = 32'd6; s_op = 3'd0; s_user = 4'd1;
        s_valid8 = 1'b0; m_ready8 = 1'b1; s_a8 = 8'd0; s_b8 = 8'd0; s_op8 = 3'd0; s_user8 = 4'd0;

        // Reset held three cycles with traffic offered.
        for (int i = 0; i < 3; i++) cyc();
        aresetn = 1'b1; s_valid = 1'b0;
        cyc();
        chk("post_rst_m_valid", {63'd0, m_valid}, 64'd0);

        // Arithmetic corner cases.
        directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 32'h0000_0000, 5'b00101);
        directed("sub_ovf",  32'h8000_0000, 32'h0000_0001, 3'd1, 32'h7FFF_FFFF, 5'b00010);
        directed("and",  32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 32'hF000_F000, 5'b01000);
        directed("or",   32'hF0F0_F0F0, 32'hFF00_FF00, 3'd3, 32'hFFF0_FFF0, 5'b01000);
        directed("xor",  32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 32'h0FF0_0FF0, 5'b00000);
        directed("xnor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, 32'hF00F_F00F, 5'b01000);
        directed("ill7", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, 32'h0000_0000, 5'b10100);
        directed("sub_borrow", 32'h0000_0001, 32'h0000_0002, 3'd1, 32'hFFFF_FFFF, 5'b01001);

        // Backpressure: 8 beats, m_ready pattern 1,0,0,1.
        for (int i = 0; i < 8; i++) begin
            ta[i] = $urandom; tb[i] = $urandom; top[i] = 3'($urandom_range(0, 7));
        end
        sent = 0; base = popped;
        for (int c = 0; c < 100 && (popped - base) < 8; c++) begin
            m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (sent < 8) begin
                s_valid = 1'b1; s_a = ta[sent]; s_b = tb[sent]; s_op = top[sent]; s_user = 4'(sent);
            end else begin
                s_valid = 1'b0;
            end
            cyc();
            if (last_acc) sent++;
        end
        s_valid = 1'b0;
        chk("bp_count", 64'(popped - base), 64'd8);

        // Reset while two beats are in flight.
        m_ready = 1'b0; s_valid = 1'b1;
        s_a = 32'd10; s_b = 32'd3; s_op = 3'd1; s_user = 4'd9;
        cyc();
        s_user = 4'd10;
        cyc();
        s_valid = 1'b0;
        cyc();
        aresetn = 1'b0;
        cyc();
        aresetn = 1'b1;
        chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("midrst_quiet", {63'd0, m_valid}, 64'd0);
            cyc();
        end

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 9) < 7);
            s_a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            s_b  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            s_op = 3'($urandom_range(0, 7));
            s_user = 4'($urandom_range(0, 15));
            cyc();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) cyc();
        chk("drain_empty", 64'(q.size()), 64'd0);

        // Narrow instance.
        s_a8 = 8'h7F; s_b8 = 8'h01; s_op8 = 3'd0; s_user8 = 4'd3; s_valid8 = 1'b1;
        cyc();
        s_valid8 = 1'b0;
        cyc();
        chk("w8_valid", {63'd0, m_valid8}, 64'd1);
        chk("w8_result", {56'd0, m_result8}, 64'h80);
        chk("w8_flags", {59'd0, m_flags8}, {59'd0, 5'b01010});
        chk("w8_user", {60'd0, m_user8}, 64'd3);
        for (int i = 0; i < 6; i++) begin
            s_a8 = 8'($urandom); s_b8 = 8'($urandom); s_op8 = 3'($urandom_range(0, 7));
            s_valid8 = 1'b1;
            model_alu(8, {56'd0, s_a8}, {56'd0, s_b8}, int'(s_op8), r8, f8);
            cyc();
            s_valid8 = 1'b0;
            cyc();
            chk("w8_rand_result", {56'd0, m_result8}, {56'd0, r8[7:0]});
            chk("w8_rand_flags", {59'd0, m_flags8}, {59'd0, f8});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
